// File: rtl/conv_pkg.sv
// Shared definitions for the convolution frame scheduler.
//   - default image geometry
//   - FSM state encoding
//   - pix_addr(): linear SRAM address of pixel (row, col) in a w-wide image
package conv_pkg;

  localparam int DEF_IMG_W    = 32;
  localparam int DEF_IMG_H    = 32;
  localparam int DEF_NUM_FILT = 5;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DIM_START = 3'd1;
  localparam logic [2:0] ST_FRM_START = 3'd2;
  localparam logic [2:0] ST_STREAM    = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;
  localparam logic [2:0] ST_DIM_END   = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  function automatic logic [31:0] pix_addr(input logic [31:0] row,
                                           input logic [31:0] col,
                                           input logic [31:0] w);
    return row * w + col;
  endfunction

endpackage

// File: rtl/conv_sched_pos_cnt.sv
// Nested position counter for the frame scheduler.
//   col  : 0..IMG_W-1, advances on adv_pix
//   row  : 0..IMG_H-1, advances when col wraps; both wrap to 0 after the
//          last pixel so the next frame starts at address 0
//   filt : 0..NUM_FILT-1, advances on adv_filt
//   clr  : synchronous clear of all three counters (wins over advance)
//   last_col/last_row/last_filt : terminal-count flags
module conv_sched_pos_cnt #(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int NUM_FILT = 5,
  parameter int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  parameter int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv_pix,
  input  logic          adv_filt,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [2:0]    filt,
  output logic          last_col,
  output logic          last_row,
  output logic          last_filt
);

  assign last_col  = (col  == CW'(IMG_W - 1));
  assign last_row  = (row  == RW'(IMG_H - 1));
  assign last_filt = (filt == 3'(NUM_FILT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      filt <= '0;
    end else if (clr) begin
      col  <= '0;
      row  <= '0;
      filt <= '0;
    end else begin
      if (adv_pix) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (adv_filt)
        filt <= last_filt ? '0 : filt + 1'b1;
    end
  end

endmodule

// File: rtl/conv_frame_sched.sv
// Convolution frame scheduler: on start, replays the stored image NUM_FILT
// times from a sync-read SRAM (1-cycle latency) and generates the framing
// strobes for the conv layer.
//   clk, rst_n          : clock, async active-low reset
//   start, abort        : run request (sampled in IDLE), synchronous cancel
//   busy, done          : run in progress, one-cycle completion pulse
//   mem_rd_en, mem_addr : SRAM read port; mem_rd_data returns next cycle
//   ima, ena_in         : pixel and pixel-valid to the conv layer
//   frame_start_in, line_start_in, frame_end_in : per-frame strobes
//   frame_start_dim_in, frame_end_dim_in        : per-run strobes
//   dim_idx             : current filter index
// Optional macro CONV_SCHED_PERF_EN adds run_cycles[19:0]: busy-cycle count
// of the last completed run.
module conv_frame_sched
  import conv_pkg::*;
#(
  parameter int IMA      = 8,
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int NUM_FILT = DEF_NUM_FILT,
  parameter int GAP      = 4,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [IMA-1:0]    mem_rd_data,
  output logic [IMA-1:0]    ima,
  output logic              ena_in,
  output logic              frame_start_in,
  output logic              line_start_in,
  output logic              frame_end_in,
  output logic              frame_start_dim_in,
  output logic              frame_end_dim_in,
  output logic [2:0]        dim_idx
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [19:0]       run_cycles
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  logic [2:0]    state, state_n;
  logic          drain;
  logic [GW-1:0] gapc;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [2:0]    filt;
  logic          last_col, last_row, last_filt;
  logic          rd, frm_last, gap_last;
  logic          ena_q, ls_q, fe_q;

  // Reads are issued from FRM_START until the last pixel; STREAM then holds
  // one extra "drain" cycle so the final beat's data/strobes come out
  // before the FSM leaves the frame.
  assign rd       = (state == ST_FRM_START) || ((state == ST_STREAM) && !drain);
  assign frm_last = rd && last_col && last_row;
  assign gap_last = (state == ST_GAP) && (gapc == GW'(GAP - 1));

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = ST_IDLE;   // also blocks a same-cycle start in IDLE
    end else begin
      case (state)
        ST_IDLE:      if (start) state_n = ST_DIM_START;
        ST_DIM_START: state_n = ST_FRM_START;
        ST_FRM_START: state_n = ST_STREAM;
        ST_STREAM:    if (drain) state_n = last_filt ? ST_DIM_END : ST_GAP;
        ST_GAP:       if (gap_last) state_n = ST_FRM_START;
        ST_DIM_END:   state_n = ST_DONE;
        ST_DONE:      state_n = ST_IDLE;
        default:      state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      drain <= 1'b0;
      gapc  <= '0;
      ena_q <= 1'b0;
      ls_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (abort || ((state == ST_STREAM) && drain))
        drain <= 1'b0;
      else if (frm_last)
        drain <= 1'b1;
      gapc  <= ((state == ST_GAP) && !gap_last && !abort) ? gapc + 1'b1 : '0;
      // Strobes ride one cycle behind the read so they align with SRAM data;
      // a read issued in the abort cycle is returned without a valid.
      ena_q <= rd && !abort;
      ls_q  <= rd && !abort && (col == '0);
      fe_q  <= frm_last && !abort;
    end
  end

  conv_sched_pos_cnt #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_FILT(NUM_FILT), .CW(CW), .RW(RW)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (abort || (state == ST_IDLE) || (state == ST_DONE)),
    .adv_pix  (rd && !abort),
    .adv_filt (gap_last && !abort),
    .col      (col),
    .row      (row),
    .filt     (filt),
    .last_col (last_col),
    .last_row (last_row),
    .last_filt(last_filt)
  );

  assign busy               = (state != ST_IDLE);
  assign done               = (state == ST_DONE);
  assign frame_start_dim_in = (state == ST_DIM_START);
  assign frame_end_dim_in   = (state == ST_DIM_END);
  assign frame_start_in     = (state == ST_FRM_START);
  assign mem_rd_en          = rd;
  assign mem_addr           = ADDR_W'(pix_addr(32'(row), 32'(col), 32'(IMG_W)));
  assign ima                = mem_rd_data;
  assign ena_in             = ena_q;
  assign line_start_in      = ls_q;
  assign frame_end_in       = fe_q;
  assign dim_idx            = filt;

`ifdef CONV_SCHED_PERF_EN
  // perf_cnt is 0 in the first busy cycle, so DONE latches perf_cnt+1.
  logic [19:0] perf_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt   <= '0;
      run_cycles <= '0;
    end else begin
      perf_cnt <= (state == ST_IDLE) ? '0 : perf_cnt + 1'b1;
      if (state == ST_DONE)
        run_cycles <= perf_cnt + 1'b1;
    end
  end
`else
  // No run-length counter in this build.
`endif

endmodule

// File: tb/tb_conv_frame_sched.sv
// Self-checking bench for conv_frame_sched (default geometry). A cycle-level
// reference model derives every expected output from the run offset t using
// frame-period arithmetic; a table of anchor points checks the first run.
module tb_conv_frame_sched;
  localparam int IMA = 8, W = 32, H = 32, NF = 5, GAP = 4, AW = 10;
  localparam int N = W * H, P = 1 + N + GAP;
  localparam int T_DE = 2 + (NF - 1) * P + N + 1;
  localparam int T_DONE = T_DE + 1;
  localparam int CAPN = 5200;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic busy, done, mem_rd_en, ena_in, frame_start_in, line_start_in;
  logic frame_end_in, frame_start_dim_in, frame_end_dim_in;
  logic [AW-1:0] mem_addr;
  logic [IMA-1:0] mem_rd_data = '0, ima;
  logic [2:0] dim_idx;
`ifdef CONV_SCHED_PERF_EN
  logic [19:0] run_cycles;
`endif

  conv_frame_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .ima(ima), .ena_in(ena_in),
    .frame_start_in(frame_start_in), .line_start_in(line_start_in),
    .frame_end_in(frame_end_in), .frame_start_dim_in(frame_start_dim_in),
    .frame_end_dim_in(frame_end_dim_in), .dim_idx(dim_idx)
`ifdef CONV_SCHED_PERF_EN
    , .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: contents are the low address byte, 1-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr[7:0];

  typedef struct packed {
    logic busy, done, rd, ena, fs, ls, fe, fsd, fed;
  } sig_t;
  typedef struct packed {
    sig_t s; logic [AW-1:0] addr; logic dim_chk; logic [2:0] dim; logic [IMA-1:0] ima;
  } exp_t;
  typedef struct { int t; sig_t s; bit dc; logic [2:0] d; } tv_t;

  int errs = 0, checks = 0, cyc = 0, t0 = 0, cap_base = 0;
  bit active = 1'b0, capture = 1'b0;
  sig_t cap_s [0:CAPN-1];
  logic [2:0] cap_d [0:CAPN-1];
  tv_t tv [11];

  // Expected outputs t cycles after the start cycle (t<0: idle).
  function automatic exp_t model(int t);
    exp_t e;
    int u, f, p, b;
    e = '0;
    if (t >= 1 && t <= T_DONE) e.s.busy = 1'b1;
    if (t == 1) begin
      e.s.fsd = 1'b1; e.dim_chk = 1'b1; e.dim = 3'd0;
    end else if (t >= 2 && t < T_DE) begin
      u = t - 2; f = u / P; p = u % P;
      if (p < N) begin e.s.rd = 1'b1; e.addr = AW'(p); e.s.fs = (p == 0); end
      if (p >= 1 && p <= N) begin
        b = p - 1;
        e.s.ena = 1'b1; e.s.ls = (b % W == 0); e.s.fe = (b == N - 1);
        e.ima = IMA'(b);
      end
      if (p <= N) begin e.dim_chk = 1'b1; e.dim = 3'(f); end
    end
    if (t == T_DE) e.s.fed = 1'b1;
    if (t == T_DONE) e.s.done = 1'b1;
    return e;
  endfunction

  task automatic check_now();
    exp_t e;
    sig_t o;
    int t;
    t = active ? cyc - t0 : -1;
    e = model(t);
    o = {busy, done, mem_rd_en, ena_in, frame_start_in, line_start_in,
         frame_end_in, frame_start_dim_in, frame_end_dim_in};
    if (capture && cyc - cap_base >= 0 && cyc - cap_base < CAPN) begin
      cap_s[cyc - cap_base] = o; cap_d[cyc - cap_base] = dim_idx;
    end
    checks++;
    if (o !== e.s) begin
      errs++;
      $display("FAIL strobes cyc=%0d t=%0d got=%b exp=%b", cyc, t, o, e.s);
    end
    if (e.s.rd) begin
      checks++;
      if (mem_addr !== e.addr) begin
        errs++; $display("FAIL addr cyc=%0d t=%0d got=%0d exp=%0d", cyc, t, mem_addr, e.addr);
      end
    end
    if (e.dim_chk) begin
      checks++;
      if (dim_idx !== e.dim) begin
        errs++; $display("FAIL dim_idx cyc=%0d t=%0d got=%0d exp=%0d", cyc, t, dim_idx, e.dim);
      end
    end
    if (e.s.ena) begin
      checks++;
      if (ima !== e.ima) begin
        errs++; $display("FAIL ima cyc=%0d t=%0d got=%0d exp=%0d", cyc, t, ima, e.ima);
      end
    end
  endtask

  // One clock: check this cycle's outputs, drive this cycle's inputs,
  // advance the model's notion of whether a run is active.
  task automatic step(input bit st, input bit ab);
    @(negedge clk);
    check_now();
    start = st; abort = ab;
    if (active && ab) active = 1'b0;
    else if (!active && st && !ab) begin active = 1'b1; t0 = cyc; end
    else if (active && cyc - t0 == T_DONE) active = 1'b0;
    cyc++;
  endtask

  // Random start pulses while busy; the DUT must ignore them.
  function automatic bit noise();
    return active && ($urandom_range(0, 63) == 0);
  endfunction

  task automatic mid_reset();
    sig_t o;
    @(negedge clk);
    check_now();
    start = 1'b0; abort = 1'b0; rst_n = 1'b0;
    #1;
    o = {busy, done, mem_rd_en, ena_in, frame_start_in, line_start_in,
         frame_end_in, frame_start_dim_in, frame_end_dim_in};
    checks++;
    if (o !== '0 || dim_idx !== 3'd0 || mem_addr !== '0) begin
      errs++; $display("FAIL async_reset got=%b dim=%0d addr=%0d exp=0", o, dim_idx, mem_addr);
    end
    active = 1'b0; cyc++;
    @(negedge clk); cyc++;
    @(negedge clk); rst_n = 1'b1; cyc++;
  endtask

  task automatic perf_check();
`ifdef CONV_SCHED_PERF_EN
    checks++;
    if (run_cycles !== 20'd5144) begin
      errs++; $display("FAIL run_cycles got=%0d exp=5144", run_cycles);
    end
`endif
  endtask

  initial begin
    int ra, n_ena, n_ls, n_fs, n_done;
    // Anchor points of the first run; strobe order busy,done,rd,ena,fs,ls,fe,fsd,fed.
    tv[0]  = '{0,    9'b000000000, 1'b0, 3'd0};
    tv[1]  = '{1,    9'b100000010, 1'b1, 3'd0};
    tv[2]  = '{2,    9'b101010000, 1'b1, 3'd0};
    tv[3]  = '{3,    9'b101101000, 1'b1, 3'd0};
    tv[4]  = '{1026, 9'b100100100, 1'b1, 3'd0};
    tv[5]  = '{1027, 9'b100000000, 1'b0, 3'd0};
    tv[6]  = '{1031, 9'b101010000, 1'b1, 3'd1};
    tv[7]  = '{5142, 9'b100100100, 1'b1, 3'd4};
    tv[8]  = '{5143, 9'b100000001, 1'b0, 3'd0};
    tv[9]  = '{5144, 9'b110000000, 1'b0, 3'd0};
    tv[10] = '{5145, 9'b000000000, 1'b0, 3'd0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 0);
    // start and abort together in IDLE: nothing starts
    step(1, 1);
    repeat (4) step(0, 0);

    // Run 1: full run, extra start at t=500, captured for the anchor table
    cap_base = cyc; capture = 1'b1;
    step(1, 0);
    for (int i = 1; i < CAPN; i++) step((i == 500) ? 1'b1 : noise(), 1'b0);
    capture = 1'b0;
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (cap_s[tv[k].t] !== tv[k].s || (tv[k].dc && cap_d[tv[k].t] !== tv[k].d)) begin
        errs++;
        $display("FAIL anchor t=%0d got=%b dim=%0d exp=%b dim=%0d",
                 tv[k].t, cap_s[tv[k].t], cap_d[tv[k].t], tv[k].s, tv[k].d);
      end
    end
    n_ena = 0; n_ls = 0; n_fs = 0; n_done = 0;
    for (int t = 0; t < CAPN; t++) begin
      n_ena += int'(cap_s[t].ena); n_ls += int'(cap_s[t].ls);
      n_fs += int'(cap_s[t].fs); n_done += int'(cap_s[t].done);
    end
    checks++;
    if (n_ena != NF * N || n_ls != NF * H || n_fs != NF || n_done != 1) begin
      errs++;
      $display("FAIL counts ena=%0d ls=%0d fs=%0d done=%0d exp %0d %0d %0d 1",
               n_ena, n_ls, n_fs, NF * N, NF * H, NF, n_done);
    end
    perf_check();

    // Run 2: abort at t=1500, restart at t=1510, then a random abort
    step(1, 0);
    for (int i = 1; i < 1500; i++) step(noise(), 1'b0);
    step(0, 1);
    for (int i = 1501; i < 1510; i++) step(0, 0);
    step(1, 0);
    ra = $urandom_range(2, T_DONE - 1);
    for (int i = 1; i < ra; i++) step(noise(), 1'b0);
    step(0, 1);
    repeat (10) step(0, 0);
    perf_check();

    // Run 3: reset at t=3000, then a normal full run
    step(1, 0);
    for (int i = 1; i < 3000; i++) step(noise(), 1'b0);
    mid_reset();
    repeat (2) step(0, 0);
    step(1, 0);
    for (int i = 1; i < CAPN; i++) step(noise(), 1'b0);
    perf_check();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
